// File: rtl/dmem_loader.sv
// dmem_loader: fill/verify sequencer for the data memory.
// Accepts a byte stream over valid/ready. In write mode each byte is written
// to consecutive dmem locations; in verify mode each byte is compared against
// dmem read port 2 and the first mismatching address is latched.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   start, mode         command strobe (IDLE only), 0 = write / 1 = verify
//   base_addr, length   first address, byte count (clamped to DEPTH)
//   abort               cancel a running command
//   in_valid, in_data   stream input; in_ready is the accept handshake
//   mem_write_*         dmem write port
//   mem_read_addr/data  dmem read port 2 (combinational read)
//   busy, done          status: busy outside IDLE, done one-cycle pulse
//   error, err_addr     sticky verify mismatch and its first address
//   count               bytes accepted in the current/last command
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | waiting for start; ports idle
// S_WRITE  | accepting bytes, writing them to dmem
// S_VERIFY | accepting bytes, comparing them with dmem
// S_DONE   | one-cycle completion pulse, then back to idle
module dmem_loader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         len_clamp;
  logic                  active;
  logic                  beat;
  logic                  last_beat;
  logic                  mismatch;
  logic                  accept_start;

  assign len_clamp    = (length > DEPTH_C) ? DEPTH_C : length;
  assign active       = (state_q == S_WRITE) || (state_q == S_VERIFY);
  // abort drops ready in the same cycle so a concurrent beat is refused
  assign in_ready     = active && !abort;
  assign beat         = in_valid && in_ready;
  assign last_beat    = beat && ((count + CW'(1)) == len_q);
  assign mismatch     = (state_q == S_VERIFY) && beat && (in_data != mem_read_data);
  assign accept_start = (state_q == S_IDLE) && start;

  assign mem_write_enable = (state_q == S_WRITE) && beat;
  assign mem_write_addr   = (state_q == S_WRITE) ? cur_addr : '0;
  assign mem_write_data   = (state_q == S_WRITE) ? in_data : '0;
  assign mem_read_addr    = cur_addr;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamp == '0) state_d = S_DONE;
          else if (mode)       state_d = S_VERIFY;
          else                 state_d = S_WRITE;
        end
      end
      S_WRITE, S_VERIFY: begin
        if (abort)          state_d = S_IDLE;
        else if (last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr <= '0;
      len_q    <= '0;
      count    <= '0;
      error    <= 1'b0;
      err_addr <= '0;
    end else if (accept_start) begin
      cur_addr <= base_addr;
      len_q    <= len_clamp;
      count    <= '0;
      error    <= 1'b0;
      err_addr <= '0;
    end else if (beat) begin
      // natural wrap of the address register gives modulo-DEPTH addressing
      cur_addr <= cur_addr + ADDR_WIDTH'(1);
      count    <= count + CW'(1);
      if (mismatch) begin
        error <= 1'b1;
        if (!error) err_addr <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_loader.sv
module tb_dmem_loader;

  localparam int CLK_P = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] length = '0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       mem_write_enable;
  logic [3:0] mem_write_addr;
  logic [7:0] mem_write_data;
  logic [3:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic       busy, done, error;
  logic [3:0] err_addr;
  logic [4:0] count;

  dmem_loader dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .base_addr(base_addr), .length(length), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .busy(busy), .done(done),
    .error(error), .err_addr(err_addr), .count(count)
  );

  always #(CLK_P/2) clk = ~clk;

  // external 16x8 dmem
  logic [7:0] mem [16];
  logic       mem_clear = 1'b1;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (mem_write_enable) begin
      mem[mem_write_addr] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_read_addr];

  // observed write pulses and done pulses
  logic [11:0] obs_wq [$];
  int          done_cnt = 0;
  always @(negedge clk) begin
    if (mem_write_enable) obs_wq.push_back({mem_write_addr, mem_write_data});
    if (done) done_cnt++;
  end

  // reference dmem contents
  logic [7:0] model_mem [16];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input bit m, input logic [3:0] b, input logic [4:0] l, input bit ab);
    @(posedge clk); #1;
    start = 1'b1; mode = m; base_addr = b; length = l; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_accepted_busy", busy, 1);
  endtask

  // Runs one command end to end and checks it against the reference model.
  task automatic run_cmd(input bit m, input logic [3:0] b, input logic [4:0] l,
                         input logic [127:0] dat, input logic [7:0] vpat, input bit rnd_valid,
                         input bit ab_at_start,
                         output logic [4:0] o_count, output bit o_err, output logic [3:0] o_ea);
    int eff, idx, j, wbase, dbase;
    logic [11:0] exp_wq [$];
    bit exp_err;
    logic [3:0] exp_ea;
    bit v;
    eff = (l > 5'd16) ? 16 : int'(l);
    exp_err = 1'b0;
    exp_ea = 4'd0;
    for (int i = 0; i < eff; i++) begin
      logic [3:0] a;
      logic [7:0] d;
      a = 4'((int'(b) + i) % 16);
      d = dat[8*i +: 8];
      if (!m) begin
        exp_wq.push_back({a, d});
        model_mem[a] = d;
      end else if (d != model_mem[a]) begin
        if (!exp_err) exp_ea = a;
        exp_err = 1'b1;
      end
    end
    wbase = obs_wq.size();
    dbase = done_cnt;
    start_cmd(m, b, l, ab_at_start);
    idx = 0;
    j = 0;
    while (idx < eff && j < 300) begin
      v = rnd_valid ? ($urandom_range(0, 2) != 0) : vpat[j % 8];
      in_valid = v;
      in_data = v ? dat[8*idx +: 8] : 8'($urandom);
      // stray start while busy must be ignored
      start = ($urandom_range(0, 3) == 0);
      mode = 1'($urandom);
      base_addr = 4'($urandom);
      length = 5'($urandom);
      @(negedge clk);
      if (v && in_ready) idx++;
      @(posedge clk); #1;
      j++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("all_beats_accepted", idx, eff);
    @(negedge clk);
    chk("done_pulse", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    chk("done_count", done_cnt - dbase, 1);
    chk("write_count", obs_wq.size() - wbase, exp_wq.size());
    for (int i = 0; i < exp_wq.size() && (wbase + i) < obs_wq.size(); i++)
      chk("write_addr_data", obs_wq[wbase + i], exp_wq[i]);
    chk("count", count, eff);
    chk("error", error, exp_err);
    chk("err_addr", err_addr, exp_ea);
    o_count = count;
    o_err = error;
    o_ea = err_addr;
  endtask

  typedef struct {
    bit          mode;
    logic [3:0]  base;
    logic [4:0]  len;
    logic [31:0] dat;
    logic [7:0]  vpat;
    logic [4:0]  exp_count;
    bit          exp_err;
    logic [3:0]  exp_ea;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [4:0] oc;
    bit oe;
    logic [3:0] oa;
    logic [127:0] dat;
    int wbase, dbase;

    vecs[0] = '{1'b0, 4'd0,  5'd4, 32'h44332211, 8'hFF, 5'd4, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 4'd0,  5'd4, 32'h40332011, 8'hFF, 5'd4, 1'b1, 4'd1};
    vecs[2] = '{1'b0, 4'd14, 5'd4, 32'hD4C3B2A1, 8'h2D, 5'd4, 1'b0, 4'd0};
    vecs[3] = '{1'b1, 4'd14, 5'd4, 32'hD4C3B2A1, 8'hFF, 5'd4, 1'b0, 4'd0};

    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_error", error, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wen", mem_write_enable, 0);
    chk("rst_raddr", mem_read_addr, 0);
    repeat (2) @(posedge clk);
    #2;
    mem_clear = 1'b0;
    reset = 1'b1;

    // directed table
    for (int k = 0; k < 4; k++) begin
      dat = {96'h0, vecs[k].dat};
      run_cmd(vecs[k].mode, vecs[k].base, vecs[k].len, dat, vecs[k].vpat, 1'b0, 1'b0, oc, oe, oa);
      chk("tbl_count", oc, vecs[k].exp_count);
      chk("tbl_error", oe, vecs[k].exp_err);
      chk("tbl_err_addr", oa, vecs[k].exp_ea);
    end

    // length 0: immediate done, no writes
    run_cmd(1'b0, 4'd7, 5'd0, 128'h0, 8'hFF, 1'b0, 1'b0, oc, oe, oa);
    chk("len0_count", oc, 0);
    // length 20 clamps to 16, starting at base 5; abort with start -> start wins
    for (int i = 0; i < 16; i++) dat[8*i +: 8] = 8'($urandom);
    run_cmd(1'b0, 4'd5, 5'd20, dat, 8'hFF, 1'b1, 1'b1, oc, oe, oa);
    chk("len20_count", oc, 16);

    // abort after 2 of 5 beats
    wbase = obs_wq.size();
    dbase = done_cnt;
    start_cmd(1'b0, 4'd5, 5'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 8'h60 + 8'(i);
      model_mem[4'(5 + i)] = in_data;
      @(negedge clk);
      @(posedge clk); #1;
    end
    abort = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_wen", mem_write_enable, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    chk("abort_count", count, 2);
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - dbase, 0);
    chk("abort_writes", obs_wq.size() - wbase, 2);
    in_valid = 1'b0;

    // asynchronous reset mid-WRITE
    start_cmd(1'b0, 4'd3, 5'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'h70 + 8'(i);
      model_mem[4'(3 + i)] = in_data;
      @(negedge clk);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_wen", mem_write_enable, 0);
    chk("arst_waddr", mem_write_addr, 0);
    chk("arst_wdata", mem_write_data, 0);
    chk("arst_raddr", mem_read_addr, 0);
    chk("arst_count", count, 0);
    chk("arst_done", done, 0);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    run_cmd(1'b0, 4'd9, 5'd3, 128'h00000000_00000000_00000000_00ABCDEF, 8'hFF, 1'b0, 1'b0, oc, oe, oa);

    // randomized commands against the reference model
    for (int n = 0; n < 25; n++) begin
      bit m;
      logic [3:0] b;
      logic [4:0] l;
      m = 1'($urandom);
      b = 4'($urandom);
      l = 5'($urandom_range(0, 20));
      for (int i = 0; i < 16; i++) begin
        if (m) dat[8*i +: 8] = model_mem[4'((int'(b) + i) % 16)] ^
                               (($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
        else   dat[8*i +: 8] = 8'($urandom);
      end
      run_cmd(m, b, l, dat, 8'hFF, 1'b1, 1'($urandom), oc, oe, oa);
    end

    // final memory image
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk("mem_image", mem[i], model_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(CLK_P * 50000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
